// File: rtl/gc_conf_writer.sv
// gc_conf_writer: per select code, fetches a header and N configuration words from memory and streams them into the selected sub-block.
// Optional macro GC_CONF_CHKSUM_EN: verifies a trailing XOR checksum word and reports a sticky conf_err on mismatch.
module gc_conf_writer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned HDR_BASE = 0
) (
  input  logic              conf_clk,
  input  logic              reset,
  input  logic [2:0]        current_select,
  input  logic              pdone,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [5:0]        blk_wr_en,
  output logic [ADDR_W-1:0] blk_wr_addr,
  output logic [DATA_W-1:0] blk_wr_data,
  output logic              conf_ack,
  output logic              conf_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_HLAT   = 3'd2,
    S_STREAM = 3'd3,
    S_CHK    = 3'd4,
    S_ACK    = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  localparam logic [ADDR_W-1:0] HDR_BASE_A = ADDR_W'(HDR_BASE);

  function automatic logic [5:0] sel_onehot(input logic [2:0] s);
    sel_onehot = 6'b000001 << (s - 3'd1);
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        done_sel_q, done_sel_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic              inflight_q, inflight_d;
  logic              rd_en_q, rd_en_d;
  logic [5:0]        wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-1:0] hdr_addr_s;
  logic [ADDR_W-1:0] hdr_start_s;
  logic [ADDR_W-1:0] hdr_count_s;
`ifdef GC_CONF_CHKSUM_EN
  logic [DATA_W-1:0] xor_q, xor_d;
  logic              err_q, err_d;
`endif

  assign hdr_addr_s  = HDR_BASE_A + ADDR_W'(current_select) - ADDR_W'(1);
  assign hdr_start_s = mem_rd_data[ADDR_W-1:0];
  assign hdr_count_s = mem_rd_data[2*ADDR_W-1:ADDR_W];

  // Next-state and registered-output logic for the fetch/stream sequencer.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    done_sel_d  = done_sel_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    wr_idx_d    = wr_idx_q;
    inflight_d  = 1'b0;
    rd_en_d     = 1'b0;
    wr_en_d     = 6'b000000;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    ack_d       = 1'b0;
`ifdef GC_CONF_CHKSUM_EN
    xor_d       = xor_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (current_select == 3'd0) begin
          done_sel_d = 3'd0;
        end else if (pdone && (current_select != 3'd7) && (current_select != done_sel_q)) begin
          sel_d   = current_select;
          rd_en_d = 1'b1;
          ptr_d   = hdr_addr_s;
          state_d = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        state_d = S_HLAT;
      end
      S_HLAT: begin
        ptr_d    = hdr_start_s;
        wr_idx_d = {ADDR_W{1'b0}};
`ifdef GC_CONF_CHKSUM_EN
        xor_d    = {DATA_W{1'b0}};
`endif
        if (hdr_count_s == {ADDR_W{1'b0}}) begin
          remaining_d = {ADDR_W{1'b0}};
`ifdef GC_CONF_CHKSUM_EN
          rd_en_d     = 1'b1;
          state_d     = S_CHK;
`else
          state_d     = S_ACK;
`endif
        end else begin
          rd_en_d     = 1'b1;
          inflight_d  = 1'b1;
          remaining_d = hdr_count_s - ADDR_W'(1);
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        // inflight_q marks that mem_rd_data carries the word read last cycle
        if (inflight_q) begin
          wr_en_d   = sel_onehot(sel_q);
          wr_addr_d = wr_idx_q;
          wr_data_d = mem_rd_data;
          wr_idx_d  = wr_idx_q + ADDR_W'(1);
`ifdef GC_CONF_CHKSUM_EN
          xor_d     = xor_q ^ mem_rd_data;
`endif
        end else begin
          wr_en_d = 6'b000000;
        end
        if (remaining_q != {ADDR_W{1'b0}}) begin
          rd_en_d     = 1'b1;
          inflight_d  = 1'b1;
          ptr_d       = ptr_q + ADDR_W'(1);
          remaining_d = remaining_q - ADDR_W'(1);
        end else begin
`ifdef GC_CONF_CHKSUM_EN
          rd_en_d = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          state_d = S_CHK;
`else
          state_d = S_ACK;
`endif
        end
      end
`ifdef GC_CONF_CHKSUM_EN
      S_CHK: begin
        if (mem_rd_data == xor_q) begin
          state_d = S_ACK;
        end else begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
`endif
      S_ACK: begin
        ack_d      = 1'b1;
        done_sel_d = sel_q;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge conf_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sel_q       <= 3'd0;
      done_sel_q  <= 3'd0;
      ptr_q       <= {ADDR_W{1'b0}};
      remaining_q <= {ADDR_W{1'b0}};
      wr_idx_q    <= {ADDR_W{1'b0}};
      inflight_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 6'b000000;
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_data_q   <= {DATA_W{1'b0}};
      ack_q       <= 1'b0;
`ifdef GC_CONF_CHKSUM_EN
      xor_q       <= {DATA_W{1'b0}};
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      done_sel_q  <= done_sel_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      wr_idx_q    <= wr_idx_d;
      inflight_q  <= inflight_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      ack_q       <= ack_d;
`ifdef GC_CONF_CHKSUM_EN
      xor_q       <= xor_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_addr    = ptr_q;
  assign blk_wr_en   = wr_en_q;
  assign blk_wr_addr = wr_addr_q;
  assign blk_wr_data = wr_data_q;
  assign conf_ack    = ack_q;
`ifdef GC_CONF_CHKSUM_EN
  assign conf_err    = err_q;
`else
  assign conf_err    = 1'b0;
`endif

endmodule

// File: tb/tb_gc_conf_writer.sv
// Scoreboard bench for gc_conf_writer: expected memory reads and write/ack/error events are queued
// from the transfer rules and a free-running monitor checks what the DUT presents, including cycle timing.
module tb_gc_conf_writer;
  localparam int DW = 32;
  localparam int AW = 8;
`ifdef GC_CONF_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          conf_clk = 1'b0;
  logic          reset;
  logic [2:0]    current_select;
  logic          pdone;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic [5:0]    blk_wr_en;
  logic [AW-1:0] blk_wr_addr;
  logic [DW-1:0] blk_wr_data;
  logic          conf_ack;
  logic          conf_err;

  gc_conf_writer #(.DATA_W(DW), .ADDR_W(AW), .HDR_BASE(0)) dut (
    .conf_clk(conf_clk), .reset(reset), .current_select(current_select), .pdone(pdone),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .blk_wr_en(blk_wr_en), .blk_wr_addr(blk_wr_addr), .blk_wr_data(blk_wr_data),
    .conf_ack(conf_ack), .conf_err(conf_err)
  );

  always #5 conf_clk = ~conf_clk;

  int cyc = 0;
  always @(posedge conf_clk) cyc <= cyc + 1;

  // Memory: the word at mem_addr is visible while mem_rd_en is high and is held afterwards.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] held;
  always @(posedge conf_clk) if (mem_rd_en) held <= mem[mem_addr];
  assign mem_rd_data = mem_rd_en ? mem[mem_addr] : held;

  typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
  typedef struct { int cyc; int kind; logic [5:0] en; logic [AW-1:0] addr; logic [DW-1:0] data; } ev_t;
  rd_t rd_q[$];
  ev_t ev_q[$];
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] pat [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [63:0] outs();
    outs = {7'd0, mem_rd_en, mem_addr, blk_wr_en, blk_wr_addr, blk_wr_data, conf_ack, conf_err};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge conf_clk);
  endtask

  task automatic monitor();
    logic err_prev = 1'b0;
    rd_t  r;
    ev_t  e;
    int   ak;
    forever begin
      @(negedge conf_clk);
      if (mem_rd_en) begin
        if (rd_q.size() == 0) fail("unexpected_read", {56'd0, mem_addr});
        else begin
          r = rd_q.pop_front();
          check("rd_cycle", 64'(cyc), 64'(r.cyc));
          check("rd_addr", {56'd0, mem_addr}, {56'd0, r.addr});
        end
      end
      if ((blk_wr_en != 6'd0) || conf_ack || (conf_err && !err_prev)) begin
        if (ev_q.size() == 0) fail("unexpected_event", {56'd0, blk_wr_en, conf_ack, conf_err});
        else begin
          e  = ev_q.pop_front();
          ak = conf_ack ? 1 : ((blk_wr_en != 6'd0) ? 0 : 2);
          check("ev_kind", 64'(ak), 64'(e.kind));
          check("ev_cycle", 64'(cyc), 64'(e.cyc));
          if (e.kind == 0) begin
            check("wr_en", {58'd0, blk_wr_en}, {58'd0, e.en});
            check("wr_addr", {56'd0, blk_wr_addr}, {56'd0, e.addr});
            check("wr_data", {32'd0, blk_wr_data}, {32'd0, e.data});
          end
        end
      end
      err_prev = conf_err;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    check("reset_outputs", outs(), 64'd0);
    current_select = 3'd0;
    rd_q.delete();
    ev_q.delete();
    reset = 1'b1;
    tick(1);
  endtask

  // Issue one transfer for select sel (called at a negedge) and queue every expected observation.
  task automatic run_sel(input logic [2:0] sel, input logic [7:0] start, input int n,
                         input bit use_pat, input bit corrupt, input bit abort);
    logic [DW-1:0] x;
    logic [AW-1:0] hdr;
    int            e0;
    bit            bad;
    for (int i = 0; i < n; i++) mem[start + 8'(i)] = use_pat ? pat[i] : $urandom;
    x = 32'd0;
    for (int i = 0; i < n; i++) x = x ^ mem[start + 8'(i)];
    if (CHK) mem[start + 8'(n)] = x ^ (corrupt ? 32'h0000_0100 : 32'd0);
    hdr = 8'(sel) - 8'd1;
    mem[hdr] = {16'h0000, 8'(n), start};
    bad = CHK && (mem[start + 8'(n)] != x);
    current_select = sel;
    pdone = 1'b1;
    e0 = cyc + 1;
    rd_q.push_back('{e0, hdr});
    for (int i = 0; i < n; i++) rd_q.push_back('{e0 + 2 + i, start + 8'(i)});
    if (CHK) rd_q.push_back('{e0 + 2 + n, start + 8'(n)});
    for (int i = 0; i < n; i++)
      ev_q.push_back('{e0 + 3 + i, 0, 6'b000001 << (sel - 3'd1), 8'(i), mem[start + 8'(i)]});
    if (bad) ev_q.push_back('{e0 + n + 3, 2, 6'd0, 8'd0, 32'd0});
    else ev_q.push_back('{e0 + n + 3 + (CHK ? 1 : 0), 1, 6'd0, 8'd0, 32'd0});
    if (abort) begin
      while (cyc < e0 + 4) @(negedge conf_clk);
      #1 reset = 1'b0;
      #1 check("abort_outputs_zero", outs(), 64'd0);
      rd_q.delete();
      ev_q.delete();
      tick(3);
      current_select = 3'd0;
      reset = 1'b1;
      tick(2);
    end else begin
      for (int k = 0; k < 600 && (rd_q.size() + ev_q.size()) != 0; k++) @(negedge conf_clk);
      check("queue_drained", 64'(rd_q.size() + ev_q.size()), 64'd0);
      tick(3);
      if (bad) begin
        for (int k = 0; k < 5; k++) begin
          check("err_sticky", {63'd0, conf_err}, 64'd1);
          tick(1);
        end
        do_reset();
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    current_select = 3'd0;
    pdone = 1'b0;
    fork
      monitor();
    join_none
    for (int k = 0; k < 6; k++) begin
      @(negedge conf_clk);
      current_select = 3'($urandom);
      pdone = 1'($urandom);
      check("reset_outputs", outs(), 64'd0);
    end
    current_select = 3'd0;
    pdone = 1'b1;
    reset = 1'b1;
    tick(20);
    check("idle_after_reset", outs(), 64'd0);

    pat[0] = 32'h0000_00A1; pat[1] = 32'h0000_00B2; pat[2] = 32'h0000_00C3; pat[3] = 32'd0;
    run_sel(3'd1, 8'h10, 3, 1'b1, 1'b0, 1'b0);
    tick(10);
    run_sel(3'd2, 8'h40, 0, 1'b0, 1'b0, 1'b0);
    run_sel(3'd3, 8'hFE, 3, 1'b0, 1'b0, 1'b0);

    current_select = 3'd0;
    tick(1);
    current_select = 3'd1;
    pdone = 1'b0;
    tick(6);
    run_sel(3'd1, 8'h20, 4, 1'b0, 1'b0, 1'b0);

    run_sel(3'd4, 8'h60, 5, 1'b0, 1'b0, 1'b1);
    run_sel(3'd4, 8'h60, 5, 1'b0, 1'b0, 1'b0);

    current_select = 3'd0;
    tick(1);
    run_sel(3'd5, 8'h80, 4, 1'b0, 1'b1, 1'b0);
    current_select = 3'd0;
    tick(1);
    run_sel(3'd6, 8'h90, 2, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      current_select = 3'd0;
      tick(1);
      run_sel(3'($urandom_range(1, 6)), 8'($urandom_range(8, 200)), int'($urandom_range(0, 40)),
              1'b0, ($urandom_range(0, 3) == 0), 1'b0);
    end

    current_select = 3'd7;
    tick(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gc_conf_writer.md
Name: gc_conf_writer

Overview:
Downstream companion of the global-controller loader FSM. For each select code (1..6) the loader presents, it fetches a header and a block of configuration words from the APB slave memory. It streams those words into the selected sub-block: clock generator, initializer, stride selector, next-state module, control signal generator or reinitializer. It then returns a single-cycle conf_ack so the loader advances to the next select.

Parameters:
DATA_W, 32, width of memory words and sub-block write data
ADDR_W, 8, memory address width; also width of word count and sub-block register index (DATA_W >= 2*ADDR_W)
HDR_BASE, 0, memory address of header for select 1; header for select s is at HDR_BASE+s-1 (mod 2^ADDR_W)

Ports:
conf_clk  in  1  configuration clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
current_select  in  3  loader select code; 0 = idle, 1..6 = sub-block, 7 = config done
pdone  in  1  memory populated; no fetch starts while low
mem_rd_en  out  1  registered memory read strobe
mem_addr  out  ADDR_W  registered memory read address
mem_rd_data  in  DATA_W  read data, valid in the cycle after the edge that sampled mem_rd_en=1
blk_wr_en  out  6  one-hot write strobe; bit s-1 targets sub-block s
blk_wr_addr  out  ADDR_W  register index within the sub-block, 0..N-1
blk_wr_data  out  DATA_W  write data
conf_ack  out  1  one-cycle completion pulse to loader
conf_err  out  1  sticky checksum error (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; ptr, remaining, inflight and done_sel cleared to 0. Reset mid-operation aborts the transfer immediately with no partial ack.
- All outputs are registered.
- Header word format: bits[ADDR_W-1:0] = start pointer; bits[2*ADDR_W-1:ADDR_W] = word count N (0..2^ADDR_W-1).
- State IDLE:
  - Start when pdone=1, current_select is in 1..6 and current_select != done_sel.
  - On start, latch sel, set mem_rd_en=1 and mem_addr=HDR_BASE+sel-1, and go to HDR.
  - current_select=0 clears done_sel to 0.
  - Select 7 keeps IDLE.
- State HDR: one wait cycle with mem_rd_en=0; go to HLAT.
- State HLAT:
  - Capture start and N from mem_rd_data.
  - If N=0, go to ACK.
  - Otherwise go to STREAM, with mem_rd_en=1 and mem_addr=start.
- State STREAM:
  - One read is issued per cycle at ptr, then ptr+1; ptr wraps modulo 2^ADDR_W.
  - Reads stop after N have been issued.
  - A one-bit valid pipe follows each read. On the next edge it registers blk_wr_en=1<<(sel-1), blk_wr_addr = index (0..N-1) and blk_wr_data=mem_rd_data.
  - Writes therefore occur on N consecutive cycles with no gaps.
  - After the last write edge, go to ACK.
- State ACK:
  - conf_ack=1 for exactly one cycle; done_sel<=sel; return to IDLE.
  - done_sel prevents re-triggering on the same select during the cycle before the loader advances.
- Latency:
  - Edge 0 is the IDLE start edge. Header captured at edge 2; writes registered at edges 3..N+2; conf_ack registered at edge N+3.
  - N=0: conf_ack at edge 3, no writes.
- current_select changes mid-transfer are ignored; the latched sel is used until ACK.
- pdone falling mid-transfer is ignored.
- blk_wr_en is never multi-hot. At most one transfer is outstanding.

Optional Feature:
- Macro: GC_CONF_CHKSUM_EN.
- Defined:
  - After the N data reads, one extra word is read at start+N (mod 2^ADDR_W). It holds the XOR of the N data words; for N=0 it is expected to be 0.
  - This adds one cycle, so conf_ack arrives at edge N+4.
  - On mismatch: no conf_ack; conf_err=1; the block enters state ERR and stays there until reset.
- Not defined: no extra read; conf_err is constant 0; latency as above.

Test Plan:
- Reset check: hold reset=0 with random inputs -> all outputs 0. Release reset with current_select=0 -> no mem_rd_en for 20 cycles.
- Nominal transfer: HDR_BASE=0; mem[0]={N=3,start=0x10}; mem[0x10..0x12]=A1,B2,C3; select 1 with pdone=1 -> blk_wr_en=6'b000001 on 3 consecutive cycles with addr 0,1,2 and data A1,B2,C3; conf_ack single pulse at edge 6; no restart while select stays 1.
- Empty block: mem[1]={N=0}; select 2 -> no blk_wr_en; conf_ack at edge 3; then select 3 starts a new fetch at mem_addr=2.
- Pointer wrap: mem[2]={N=3,start=0xFE}; select 3 -> reads at 0xFE, 0xFF, 0x00; writes to blk_wr_en bit 2.
- Gating and abort:
  - select 1 with pdone=0 -> idle until pdone=1, then the fetch starts the next cycle.
  - Assert reset during the 2nd write -> outputs 0 at once and no conf_ack. After release, done_sel=0, so the same select reruns in full.
- GC_CONF_CHKSUM_EN:
  - Correct XOR -> conf_ack at edge N+4.
  - Corrupted checksum -> conf_err=1, no conf_ack, held until reset.
